// File: rtl/max_min_tracker.sv
// Streaming max/min tracker: collects FRAME_LEN unsigned samples over valid/ready
// and presents the frame's largest/smallest value with a one-cycle result strobe.
module max_min_tracker #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           in_valid,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           in_ready,
  output logic                           busy,
  output logic [$clog2(FRAME_LEN+1)-1:0] count,
  output logic                           out_valid,
  output logic [WIDTH-1:0]               max_out,
  output logic [WIDTH-1:0]               min_out
);

  localparam int unsigned CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LastCount = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] run_max_q, run_max_d;
  logic [WIDTH-1:0] run_min_q, run_min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_valid_q, out_valid_d;

  logic             xfer;
  logic             last_xfer;
  logic [WIDTH-1:0] upd_max;
  logic [WIDTH-1:0] upd_min;

  // Only COLLECT can consume a sample; ties leave the running values untouched.
  assign xfer      = in_valid && (state_q == StCollect);
  assign last_xfer = xfer && (count_q == LastCount);
  assign upd_max   = (in_data > run_max_q) ? in_data : run_max_q;
  assign upd_min   = (in_data < run_min_q) ? in_data : run_min_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StCollect;
      StCollect: if (last_xfer) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    run_max_d   = run_max_q;
    run_min_d   = run_min_q;
    max_d       = max_q;
    min_d       = min_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          run_max_d = '0;
          run_min_d = '1;
          count_d   = '0;
        end
      end
      StCollect: begin
        if (xfer) begin
          run_max_d = upd_max;
          run_min_d = upd_min;
          count_d   = count_q + CW'(1);
        end
        // Results include the final sample, so load from the updated values.
        if (last_xfer) begin
          max_d       = upd_max;
          min_d       = upd_min;
          out_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_max_q   <= '0;
      run_min_q   <= '0;
      max_q       <= '0;
      min_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      run_max_q   <= run_max_d;
      run_min_q   <= run_min_d;
      max_q       <= max_d;
      min_q       <= min_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == StCollect);
    busy      = (state_q != StIdle);
    count     = count_q;
    out_valid = out_valid_q;
    max_out   = max_q;
    min_out   = min_q;
  end

endmodule

// File: doc/max_min_tracker.md
# max_min_tracker

Streaming, sequential counterpart of the combinational two-input max/min comparator. It accepts a frame of FRAME_LEN unsigned samples over a valid/ready handshake and tracks the running maximum and minimum. At the end of each frame it presents the frame's Max/Min with a one-cycle result strobe. It sits between a sample source (switch/FIFO front end) and the display/result logic of the lab design.

## Interface

**Parameters**
- WIDTH, 4, sample width in bits; all comparisons are unsigned.
- FRAME_LEN, 8, samples per frame; legal range ≥ 2.

**Ports**
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- in_valid  in  1  source has a sample on in_data.
- in_data  in  WIDTH  sample value.
- in_ready  out  1  block will accept a sample this cycle; combinational, equal to (state == COLLECT).
- busy  out  1  high in COLLECT and DONE.
- count  out  $clog2(FRAME_LEN+1)  samples accepted in the current frame.
- out_valid  out  1  one-cycle strobe: max_out/min_out hold a new frame result.
- max_out  out  WIDTH  largest sample of the last completed frame.
- min_out  out  WIDTH  smallest sample of the last completed frame.

## Operation

- **States:** IDLE, COLLECT, DONE; registered FSM.
- **Transfer:** a transfer occurs on a rising edge where in_valid && in_ready. No other condition consumes a sample.
- **IDLE**
  - in_ready=0, busy=0.
  - start=1 → COLLECT. Same edge: run_max←0, run_min←all ones, count←0.
- **COLLECT**
  - On each transfer:
    - run_max←(in_data > run_max) ? in_data : run_max
    - run_min←(in_data < run_min) ? in_data : run_min
    - count←count+1
  - in_valid=0 cycles are stalls: no state change, no timeout.
  - The transfer that makes count reach FRAME_LEN → DONE. Same edge:
    - max_out/min_out are loaded with the updated running values, which include the final sample.
    - out_valid←1.
- **DONE**
  - Lasts exactly one cycle, then → IDLE.
  - out_valid←0 on the exit edge.
  - in_ready=0; a sample offered here is not consumed.
- **start outside IDLE:** ignored, including in DONE. It does not restart, queue, or extend the frame.
- **Holding results:** max_out/min_out change only on the COLLECT→DONE edge. Between frames they hold the last result.
- **count**
  - Holds FRAME_LEN through DONE and IDLE.
  - Clears only on the next accepted start.
- **Ties:** equal samples leave the running values unchanged. A frame of identical samples yields max_out == min_out == that value.
- **Width rules:** all running registers are WIDTH bits, with no sign extension. count never exceeds FRAME_LEN and never wraps.

## Timing

- **Reset (rst_n=0, immediate, asynchronous):**
  - state=IDLE
  - in_ready=0, busy=0, out_valid=0
  - count=0, max_out=0, min_out=0
  - running registers cleared
- **Reset mid-frame:** the partial frame is discarded with no out_valid. After rst_n rises, outputs hold reset values until the next start.
- **Cycle timing:**
  - start sampled at edge t0 → in_ready=1 from t0 onward. The earliest transfer is at edge t0+1.
  - Minimum frame duration: FRAME_LEN transfer edges plus the DONE cycle.
  - Last transfer at edge k → out_valid=1, with results valid, from k to k+1.
  - Earliest next start is accepted at edge k+2.
- **Result latency:** 1 edge from the last transfer.
- **Throughput:** one sample per cycle while in_valid stays high. No bubbles inside a frame.

## Test plan

1. **Ascending frame.** Reset, start, then in_data 0..7 back-to-back with in_valid=1. Expect out_valid for one cycle, max_out=7, min_out=0, count=8, and in_ready low on the cycle after the 8th transfer.
2. **Equal and extreme values.** Frame of eight 4'hA gives max_out=min_out=4'hA. Frame {F,0,F,0,…} gives max_out=F, min_out=0.
3. **Stalls.** Frame 3,9,1,C,5,E,2,7 with in_valid dropped for 2 cycles between every sample. Expect max_out=E, min_out=1, and count increments only on transfer edges.
4. **Ignored start.** Pulse start mid-COLLECT and again in the DONE cycle. Expect the frame unaffected (result as in scenario 1), the FSM back in IDLE, and no new frame until start is pulsed in IDLE.
5. **Mid-frame reset.** Assert rst_n=0 after 5 transfers. Expect all outputs at reset values immediately and no out_valid. Then a fresh frame 8,8,8,8,8,8,8,4 gives max_out=8, min_out=4.
6. **Back-to-back frames.** Result 7/0 holds through IDLE. Second frame 5,6,5,6,5,6,5,6 updates to 6/5 only on its out_valid cycle.
